// File: rtl/rob_fill_arbiter_if.sv
// ROB fill arbiter bus: per-unit results in, one fill port out.
// slave = arbiter side, master = units/ROB side.
interface rob_fill_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx;
  logic [NUM_REQ*DATA_W-1:0]    req_data;
  logic [NUM_REQ-1:0]           req_exc;

  logic                 fill_valid;
  logic                 fill_ready;
  logic [ROB_IDX_W-1:0] fill_rob_idx;
  logic [DATA_W-1:0]    fill_data;
  logic                 fill_exc;
  logic [SRC_W-1:0]     fill_src;

  modport slave (
    input  req_valid,
    input  req_rob_idx,
    input  req_data,
    input  req_exc,
    input  fill_ready,
    output req_ready,
    output fill_valid,
    output fill_rob_idx,
    output fill_data,
    output fill_exc,
    output fill_src
  );

  modport master (
    output req_valid,
    output req_rob_idx,
    output req_data,
    output req_exc,
    output fill_ready,
    input  req_ready,
    input  fill_valid,
    input  fill_rob_idx,
    input  fill_data,
    input  fill_exc,
    input  fill_src
  );
endinterface

// File: rtl/rob_fill_arbiter.sv
// Round-robin arbiter sharing the ROB fill port among NUM_REQ units.
// Ports: clk, rst_n (sync, low), flush, bus (slave: req_* in, fill_* out).
module rob_fill_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_IDX_W = 5,
  parameter int DATA_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  rob_fill_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [SRC_W-1:0]     r_rr_ptr;
  logic                 r_fill_valid;
  logic [ROB_IDX_W-1:0] r_fill_rob_idx;
  logic [DATA_W-1:0]    r_fill_data;
  logic                 r_fill_exc;
  logic [SRC_W-1:0]     r_fill_src;

  logic                 w_can_load;
  logic                 w_gnt_found;
  logic [SRC_W-1:0]     w_gnt_idx;
  logic                 w_load;
  logic [NUM_REQ-1:0]   w_req_ready;

  function automatic logic [SRC_W-1:0] wrap_add(
    input logic [SRC_W-1:0] p,
    input int               k
  );
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  // rst_n gates can_load so req_ready stays low during reset.
  assign w_can_load = rst_n & ~flush &
                      (~r_fill_valid | bus.fill_ready);

  // Scan from the top down so the lowest offset from
  // rr_ptr is the last writer and wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[wrap_add(r_rr_ptr, k)]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = wrap_add(r_rr_ptr, k);
      end
    end
  end

  assign w_load = w_can_load & w_gnt_found;

  always_comb begin
    w_req_ready = '0;
    if (w_load) w_req_ready = NUM_REQ'(1) << w_gnt_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr       <= '0;
      r_fill_valid   <= 1'b0;
      r_fill_rob_idx <= '0;
      r_fill_data    <= '0;
      r_fill_exc     <= 1'b0;
      r_fill_src     <= '0;
    end else if (flush) begin
      r_fill_valid <= 1'b0;
    end else if (w_load) begin
      r_fill_valid   <= 1'b1;
      r_fill_rob_idx <= bus.req_rob_idx[
        int'(w_gnt_idx)*ROB_IDX_W +: ROB_IDX_W];
      r_fill_data    <= bus.req_data[
        int'(w_gnt_idx)*DATA_W +: DATA_W];
      r_fill_exc     <= bus.req_exc[w_gnt_idx];
      r_fill_src     <= w_gnt_idx;
      r_rr_ptr       <= wrap_add(w_gnt_idx, 1);
    end else if (bus.fill_ready) begin
      r_fill_valid <= 1'b0;
    end
  end

  assign bus.req_ready    = w_req_ready;
  assign bus.fill_valid   = r_fill_valid;
  assign bus.fill_rob_idx = r_fill_rob_idx;
  assign bus.fill_data    = r_fill_data;
  assign bus.fill_exc     = r_fill_exc;
  assign bus.fill_src     = r_fill_src;
endmodule

// File: tb/tb_rob_fill_arbiter.sv
// Scoreboard bench for rob_fill_arbiter.
// Model predicts grants; queue holds expected fills.
module tb_rob_fill_arbiter;
  localparam int NR = 4;
  localparam int IW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
    logic          exc;
    logic [1:0]    src;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  logic fill_ready;

  logic [NR-1:0] u_v;
  logic [IW-1:0] u_idx [NR];
  logic [DW-1:0] u_data[NR];
  logic [NR-1:0] u_exc;

  exp_t          q[$];
  logic          m_fv;
  logic [1:0]    m_ptr;
  logic [NR-1:0] m_acc;
  int            n_checks;
  int            n_errors;

  rob_fill_arbiter_if #(
    .NUM_REQ(NR), .ROB_IDX_W(IW), .DATA_W(DW)
  ) bus ();

  rob_fill_arbiter #(
    .NUM_REQ(NR), .ROB_IDX_W(IW), .DATA_W(DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always_comb begin
    bus.req_valid  = u_v;
    bus.req_exc    = u_exc;
    bus.fill_ready = fill_ready;
    bus.req_rob_idx = '0;
    bus.req_data    = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_rob_idx[i*IW +: IW] = u_idx[i];
      bus.req_data[i*DW +: DW]    = u_data[i];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // One clock: check outputs, advance model, step edge.
  task automatic cycle();
    logic          cl;
    logic          found;
    logic [1:0]    g;
    logic [1:0]    p;
    logic [NR-1:0] rdy;
    exp_t          e;
    #1;
    cl    = rst_n & ~flush & (~m_fv | fill_ready);
    found = 1'b0;
    g     = '0;
    for (int k = 0; k < NR; k++) begin
      p = m_ptr + 2'(k);
      if (!found && u_v[p]) begin
        found = 1'b1;
        g     = p;
      end
    end
    rdy = '0;
    if (cl && found) rdy[g] = 1'b1;
    chk("req_ready", 64'(bus.req_ready), 64'(rdy));
    chk("fill_valid", 64'(bus.fill_valid), 64'(m_fv));
    if (m_fv && q.size() > 0) begin
      chk("fill_idx", 64'(bus.fill_rob_idx), 64'(q[0].idx));
      chk("fill_data", 64'(bus.fill_data), 64'(q[0].data));
      chk("fill_exc", 64'(bus.fill_exc), 64'(q[0].exc));
      chk("fill_src", 64'(bus.fill_src), 64'(q[0].src));
    end
    m_acc = '0;
    if (!rst_n) begin
      m_fv  = 1'b0;
      m_ptr = '0;
      q.delete();
    end else if (flush) begin
      if (m_fv && q.size() > 0) void'(q.pop_front());
      m_fv = 1'b0;
    end else begin
      if (m_fv && fill_ready) begin
        if (q.size() > 0) void'(q.pop_front());
        m_fv = 1'b0;
      end
      if (cl && found) begin
        e.idx  = u_idx[g];
        e.data = u_data[g];
        e.exc  = u_exc[g];
        e.src  = g;
        q.push_back(e);
        m_fv     = 1'b1;
        m_ptr    = g + 2'd1;
        m_acc[g] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(
    input int            i,
    input logic [IW-1:0] idx,
    input logic [DW-1:0] data,
    input logic          exc
  );
    u_idx[i]  = idx;
    u_data[i] = data;
    u_exc[i]  = exc;
  endtask

  logic [IW-1:0] t2_idx[NR];

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_fv       = 1'b0;
    m_ptr      = '0;
    m_acc      = '0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    fill_ready = 1'b1;
    t2_idx[0] = 5'd3;
    t2_idx[1] = 5'd7;
    t2_idx[2] = 5'd12;
    t2_idx[3] = 5'd31;
    for (int i = 0; i < NR; i++)
      set_unit(i, t2_idx[i], 32'h1000 + 32'(i), 1'b0);
    u_v = '1;
    @(posedge clk);
    #1;

    // T1: reset with all units valid
    cycle();
    cycle();
    chk("rst_valid", 64'(bus.fill_valid), 64'd0);
    chk("rst_data", 64'(bus.fill_data), 64'd0);
    chk("rst_src", 64'(bus.fill_src), 64'd0);
    rst_n = 1'b1;

    // T2: round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t2_valid", 64'(bus.fill_valid), 64'd1);
      chk("t2_src", 64'(bus.fill_src), 64'(k % NR));
      chk("t2_idx", 64'(bus.fill_rob_idx),
          64'(t2_idx[k % NR]));
    end
    u_v = '0;
    cycle();

    // T3: backpressure on unit2 result
    set_unit(2, 5'd9, 32'hDEADBEEF, 1'b0);
    u_v = 4'b0100;
    cycle();
    u_v = 4'b0001;
    set_unit(0, 5'd4, 32'h0000_0044, 1'b0);
    fill_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_hold", 64'(bus.fill_data), 64'hDEADBEEF);
      chk("t3_rdy", 64'(bus.req_ready), 64'd0);
    end
    fill_ready = 1'b1;
    cycle();
    chk("t3_nobubble", 64'(bus.fill_valid), 64'd1);
    chk("t3_next", 64'(bus.fill_src), 64'd0);
    u_v = '0;

    // T4: pointer to 3, then skip/wrap
    u_v = 4'b0100;
    cycle();
    u_v = 4'b0010;
    cycle();
    chk("t4_skip", 64'(bus.fill_src), 64'd1);
    u_v = 4'b1001;
    cycle();
    chk("t4_u3", 64'(bus.fill_src), 64'd3);
    u_v = 4'b0001;
    cycle();
    chk("t4_wrap", 64'(bus.fill_src), 64'd0);

    // T5: flush with held result and unit0 valid
    set_unit(0, 5'd21, 32'h5555_AAAA, 1'b0);
    flush = 1'b1;
    cycle();
    chk("t5_flush", 64'(bus.fill_valid), 64'd0);
    flush = 1'b0;
    cycle();
    chk("t5_regrant", 64'(bus.fill_src), 64'd0);
    chk("t5_data", 64'(bus.fill_data), 64'h5555_AAAA);
    u_v = '0;

    // T6: exception and source index
    set_unit(3, 5'd31, 32'hCAFE_0003, 1'b1);
    u_v = 4'b1000;
    cycle();
    chk("t6_exc", 64'(bus.fill_exc), 64'd1);
    chk("t6_src", 64'(bus.fill_src), 64'd3);
    chk("t6_idx", 64'(bus.fill_rob_idx), 64'd31);
    u_v = '0;
    cycle();

    // Random stalls, flushes and requesters
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (m_acc[i]) u_v[i] = 1'b0;
        if (!u_v[i] && ($urandom_range(1, 0) == 1)) begin
          u_v[i] = 1'b1;
          set_unit(i, IW'($urandom), $urandom,
                   1'($urandom));
        end
      end
      fill_ready = ($urandom_range(3, 0) != 0);
      flush      = ($urandom_range(19, 0) == 0);
      cycle();
    end

    u_v        = '0;
    flush      = 1'b0;
    fill_ready = 1'b1;
    cycle();
    cycle();
    chk("sb_empty", 64'(q.size()), 64'd0);
    chk("end_valid", 64'(bus.fill_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
